mux4_rr_arbiter: RTL and testbench

- Shares one 4:1 single-bit mux path (4-bit data in, 2-bit select, 1-bit out) among four requesters.
- Round-robin arbitration with a bounded hold time per grant.
- Drives the select, produces a one-hot grant, and registers the selected bit as a qualified output.
- Sits between the requester logic and the shared 1-bit output line.

---
 rtl/mux4_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter sharing a 4:1 one-bit mux path with bounded hold
// Optional MUX_ARB_FIXED_PRIO_EN: arbitration always searches from index 0 (lowest index wins).
module mux4_rr_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] in_data,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       out,
    output logic       out_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [0:0] state;
    logic [7:0] hold_count;
    logic [1:0] arb_start;
    logic [1:0] winner;
    logic       hold_done;
    logic       rearb;

`ifndef MUX_ARB_FIXED_PRIO_EN
    logic [1:0] last;
`endif

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // While busy, last equals sel, so last+1 covers both the idle and re-arbitration searches.
    always_comb begin
`ifdef MUX_ARB_FIXED_PRIO_EN
        arb_start = 2'd0;
`else
        arb_start = last + 2'd1;
`endif
        winner    = pick(req, arb_start);
        hold_done = !req[sel] || (hold_count == HOLD_LAST);
        rearb     = (state == IDLE) || hold_done;
    end

    assign busy = |grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 4'b0000;
            sel        <= 2'd0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            hold_count <= 8'd0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last       <= 2'd3;
`endif
        end else begin
            out       <= in_data[sel];
            out_valid <= busy;
            if (rearb) begin
                hold_count <= 8'd0;
                if (|req) begin
                    state <= BUSY;
                    grant <= 4'b0001 << winner;
                    sel   <= winner;
`ifndef MUX_ARB_FIXED_PRIO_EN
                    last  <= winner;
`endif
                end else begin
                    state <= IDLE;
                    grant <= 4'b0000;
                end
            end else begin
                hold_count <= hold_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed scoreboard bench for mux4_rr_arbiter (HOLD 4 and HOLD 2 instances)
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       o;
        logic       v;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] req2 = 4'b0000;
    logic [3:0] in_data = 4'b0000;

    logic [3:0] grant, grant2;
    logic [1:0] sel, sel2;
    logic       busy, busy2, out, out2, out_valid, out_valid2;

    int tests = 0;
    int fails = 0;
    obs_t exp_q[$];

    mux4_rr_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .in_data(in_data),
        .grant(grant), .sel(sel), .busy(busy), .out(out), .out_valid(out_valid)
    );

    mux4_rr_arbiter #(.HOLD_CYCLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .req(req2), .in_data(in_data),
        .grant(grant2), .sel(sel2), .busy(busy2), .out(out2), .out_valid(out_valid2)
    );

    always #5 clk = ~clk;

    // which=0 drives/checks the HOLD=4 instance, which=1 the HOLD=2 instance
    task automatic step(input int which, input string tag, input logic rn, input logic [3:0] r,
                        input logic [3:0] d, input logic [3:0] eg, input logic [1:0] es,
                        input logic eo, input logic ev);
        obs_t e, a;
        reset_n = rn;
        in_data = d;
        req     = (which == 0) ? r : 4'b0000;
        req2    = (which == 1) ? r : 4'b0000;
        e = '{g: eg, s: es, b: |eg, o: eo, v: ev};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (which == 0) a = '{g: grant, s: sel, b: busy, o: out, v: out_valid};
        else            a = '{g: grant2, s: sel2, b: busy2, o: out2, v: out_valid2};
        e = exp_q.pop_front();
        tests++;
        assert (a === e) else begin
            fails++;
            $error("FAIL %s: got g=%b s=%0d b=%b o=%b v=%b, want g=%b s=%0d b=%b o=%b v=%b",
                   tag, a.g, a.s, a.b, a.o, a.v, e.g, e.s, e.b, e.o, e.v);
        end
    endtask

    function automatic logic [1:0] rr_win(input int k, input int hold);
`ifdef MUX_ARB_FIXED_PRIO_EN
        rr_win = 2'd0;
`else
        rr_win = 2'(((k - 1) / hold) % 4);
`endif
    endfunction

    initial begin
        logic [1:0] w, wp;
        step(0, "reset0", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(0, "reset1", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Single requester: grant, then out/out_valid one cycle behind
        step(0, "t1_grant", 1'b1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(0, "t1_out",   1'b1, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
        step(0, "t1_drop",  1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
        step(0, "t1_vlow",  1'b1, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);

        // All requesting, HOLD=4 rotation (restart from reset so requester 0 wins first)
        step(0, "t2_reset", 1'b0, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            w  = rr_win(k, 4);
            wp = (k == 1) ? 2'd0 : rr_win(k - 1, 4);
            step(0, $sformatf("t2_rot%0d", k), 1'b1, 4'b1111, 4'b1010,
                 4'b0001 << w, w, wp[0], k != 1);
        end

        // Early release and re-grant of a lone requester; sel held through idle
        step(0, "t3_idle",  1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1);
        step(0, "t3_gnt",   1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
        step(0, "t3_hold",  1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
        step(0, "t3_rel",   1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
        step(0, "t3_idle2", 1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
        step(0, "t3_regnt", 1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(0, "t3_rel2",  1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
        step(0, "t3_idle3", 1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);

        // Reset in the middle of a grant with count=1
        step(0, "t5_gnt",   1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
        step(0, "t5_cnt1",  1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
        step(0, "t5_rst",   1'b0, 4'b0010, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(0, "t5_first", 1'b1, 4'b1111, 4'b0010, 4'b0001, 2'd0, 1'b0, 1'b0);
        step(0, "t5_drop",  1'b1, 4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1);

        // HOLD=2 instance: lone holder stays granted without gaps
        step(1, "t4_reset", 1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1, "t4_gnt",   1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0);
        for (int k = 2; k <= 8; k++)
            step(1, $sformatf("t4_hold%0d", k), 1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
        step(1, "t4_drop",  1'b1, 4'b0000, 4'b1010, 4'b0000, 2'd3, 1'b1, 1'b1);

        // HOLD=2 rotation starting after last=3
        for (int k = 1; k <= 9; k++) begin
            w  = rr_win(k, 2);
            wp = (k == 1) ? 2'd3 : rr_win(k - 1, 2);
            step(1, $sformatf("t4_rot%0d", k), 1'b1, 4'b1111, 4'b1010,
                 4'b0001 << w, w, wp[0], k != 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
